register_file_np: RTL

Parametrised multi-read-port register file for the MIPS datapath, generalising the fixed 8-bit, 32-entry, two-read-port register file. It adds configurable data width, address width and read-port count, plus a sequential clear engine that zeroes the array after reset. An optional same-cycle write-to-read bypass is also provided. It sits between decode (read addresses) and writeback (write port).

---
 rtl/register_file_pkg.sv | 14 +
 rtl/register_file_rdport.sv | 43 ++++
 rtl/register_file_np.sv | 98 +++++++++
 3 files changed

// File: rtl/register_file_pkg.sv
// Shared constants for the parametrised MIPS register file: FSM state
// encodings and default parameter values.
package register_file_pkg;

    localparam int WIDTH_DEF  = 8;
    localparam int ADDR_W_DEF = 5;
    localparam int NREAD_DEF  = 2;

    typedef logic [0:0] state_t;

    localparam state_t ST_CLEAR = 1'b0;
    localparam state_t ST_RUN   = 1'b1;

endpackage

// File: rtl/register_file_rdport.sv
// One combinational read path: array select, zero forcing and, when
// REGFILE_BYPASS_EN is defined, same-cycle write-through.
module register_file_rdport
    import register_file_pkg::*;
#(
    parameter int WIDTH  = WIDTH_DEF,
    parameter int ADDR_W = ADDR_W_DEF
) (
    input  logic [(2**ADDR_W)*WIDTH-1:0] mem,
    input  logic [ADDR_W-1:0]            ra,
    input  logic                         rd_en,
    input  logic                         regwrite,
    input  logic [ADDR_W-1:0]            wa,
    input  logic [WIDTH-1:0]             wd,
    output logic [WIDTH-1:0]             rd
);

`ifndef REGFILE_BYPASS_EN
    logic unused_s;
    assign unused_s = ^{regwrite, wa, wd};
`endif

    // Read mux; zero forcing outranks bypass so r0 and the clear sweep always read 0
    always_comb begin
        rd = '0;
        if (!rd_en) begin
            rd = '0;
        end else if (ra == '0) begin
            rd = '0;
        end else begin
`ifdef REGFILE_BYPASS_EN
            if (regwrite && (wa == ra)) begin
                rd = wd;
            end else begin
                rd = mem[ra*WIDTH +: WIDTH];
            end
`else
            rd = mem[ra*WIDTH +: WIDTH];
`endif
        end
    end

endmodule

// File: rtl/register_file_np.sv
// Multi-read-port register file with post-reset clear sweep.
// Optional same-cycle write-to-read bypass under REGFILE_BYPASS_EN.
module register_file_np
    import register_file_pkg::*;
#(
    parameter int WIDTH  = WIDTH_DEF,
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int NREAD  = NREAD_DEF
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    regwrite,
    input  logic [ADDR_W-1:0]       wa,
    input  logic [WIDTH-1:0]        wd,
    input  logic [NREAD*ADDR_W-1:0] ra,
    output logic [NREAD*WIDTH-1:0]  rd,
    output logic                    ready
);

    localparam int DEPTH = 2 ** ADDR_W;
    localparam logic [ADDR_W-1:0] PTR_START = ADDR_W'(1);
    localparam logic [ADDR_W-1:0] PTR_LAST  = ADDR_W'(DEPTH - 1);

    state_t                 state_r;
    logic [ADDR_W-1:0]      ptr_r;
    logic [WIDTH-1:0]       mem_r [DEPTH];
    logic [DEPTH*WIDTH-1:0] mem_flat_s;
    logic                   clearing_s;
    logic                   wr_en_s;
    logic                   rd_en_s;

    assign clearing_s = (state_r == ST_CLEAR);
    assign wr_en_s    = (state_r == ST_RUN) && regwrite && (wa != '0);
    // Reads are also blanked while reset is asserted, before the FSM has left RUN
    assign rd_en_s    = (state_r == ST_RUN) && !reset;
    assign ready      = (state_r == ST_RUN);

    // Clear/run FSM and sweep pointer; pointer parks on the last entry instead of wrapping
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r <= ST_CLEAR;
            ptr_r   <= PTR_START;
        end else begin
            case (state_r)
                ST_CLEAR: begin
                    if (ptr_r == PTR_LAST) begin
                        state_r <= ST_RUN;
                    end else begin
                        ptr_r <= ptr_r + ADDR_W'(1);
                    end
                end
                ST_RUN: begin
                    state_r <= ST_RUN;
                end
                default: begin
                    state_r <= ST_CLEAR;
                    ptr_r   <= PTR_START;
                end
            endcase
        end
    end

    // Storage write port: sweep zeroes during CLEAR, normal writes only in RUN
    always_ff @(posedge clk) begin
        if (!reset && clearing_s) begin
            mem_r[ptr_r] <= '0;
        end else if (!reset && wr_en_s) begin
            mem_r[wa] <= wd;
        end
    end

    genvar g;
    generate
        for (g = 0; g < DEPTH; g++) begin : g_flat
            if (g == 0) begin : g_zero
                assign mem_flat_s[g*WIDTH +: WIDTH] = '0;
            end else begin : g_entry
                assign mem_flat_s[g*WIDTH +: WIDTH] = mem_r[g];
            end
        end

        for (g = 0; g < NREAD; g++) begin : g_rd
            register_file_rdport #(
                .WIDTH  (WIDTH),
                .ADDR_W (ADDR_W)
            ) u_rdport (
                .mem      (mem_flat_s),
                .ra       (ra[g*ADDR_W +: ADDR_W]),
                .rd_en    (rd_en_s),
                .regwrite (regwrite),
                .wa       (wa),
                .wd       (wd),
                .rd       (rd[g*WIDTH +: WIDTH])
            );
        end
    endgenerate

endmodule
